// File: rtl/udp_panel_writer.sv
// rtl/udp_panel_writer.sv - UDP payload stream to HUB75 panel colour-memory write strobes
module udp_panel_writer #(
    parameter int          NUM_PANELS       = 6,
    parameter int          PIXELS_PER_PANEL = 4096,
    parameter logic [15:0] UDP_PORT         = 16'd6000
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  udp_source_valid,
    input  logic                  udp_source_last,
    output logic                  udp_source_ready,
    input  logic [15:0]           udp_source_dst_port,
    input  logic [31:0]           udp_source_data,
    output logic [NUM_PANELS-1:0] ctrl_en,
    output logic [3:0]            ctrl_wr,
    output logic [15:0]           ctrl_addr,
    output logic [23:0]           ctrl_wdat,
    output logic                  busy,
    output logic [15:0]           pkt_count,
    output logic [15:0]           err_count
);

    typedef enum logic [2:0] {IDLE, PIXELS, FILL_COLOR, FILL, DROP} state_t;

    localparam logic [7:0]            OP_PIXELS = 8'hA5;
    localparam logic [7:0]            OP_FILL   = 8'hF1;
    localparam logic [7:0]            NP8       = 8'(NUM_PANELS);
    // 17 bits so a full 65536-pixel panel never wraps the address register
    localparam logic [16:0]           PIX_END   = 17'(PIXELS_PER_PANEL);
    localparam logic [NUM_PANELS-1:0] ONE_HOT0  = NUM_PANELS'(1);

    state_t                  state, next_state;
    logic [16:0]             addr_q, addr_nxt;
    logic                    ovf_q, ovf_nxt;
    logic [NUM_PANELS-1:0]   mask_q, mask_nxt, hdr_mask, en_d;
    logic [23:0]             color_q, color_nxt, wdat_d;
    logic [15:0]             addr_d;
    logic                    pkt_inc, err_inc;

    logic       acc;
    logic [7:0] opcode, idx;
    logic       hdr_ok, in_range;

    assign acc      = udp_source_valid & udp_source_ready;
    assign opcode   = udp_source_data[31:24];
    assign idx      = udp_source_data[23:16];
    assign hdr_ok   = (udp_source_dst_port == UDP_PORT)
                    && (opcode == OP_PIXELS || opcode == OP_FILL)
                    && (idx == 8'hFF || idx < NP8);
    assign hdr_mask = (idx == 8'hFF) ? '1 : (ONE_HOT0 << idx[2:0]);
    assign in_range = (addr_q < PIX_END);

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= next_state;
    end

    // Next-state decision from the accepted word and fill progress
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (acc) begin
                if (!hdr_ok)                next_state = udp_source_last ? IDLE : DROP;
                else if (udp_source_last)   next_state = IDLE;
                else if (opcode == OP_FILL) next_state = FILL_COLOR;
                else                        next_state = PIXELS;
            end
            PIXELS:     if (acc && udp_source_last) next_state = IDLE;
            FILL_COLOR: if (acc) next_state = udp_source_last ? FILL : DROP;
            FILL:       if (addr_q == PIX_END - 17'd1) next_state = IDLE;
            DROP:       if (acc && udp_source_last) next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

    // Write strobes, datapath updates and counter events for this cycle
    always_comb begin
        en_d      = '0;
        addr_d    = ctrl_addr;
        wdat_d    = ctrl_wdat;
        pkt_inc   = 1'b0;
        err_inc   = 1'b0;
        addr_nxt  = addr_q;
        ovf_nxt   = ovf_q;
        mask_nxt  = mask_q;
        color_nxt = color_q;
        case (state)
            IDLE: if (acc) begin
                if (!hdr_ok) begin
                    err_inc = 1'b1;
                end else if (opcode == OP_PIXELS) begin
                    addr_nxt = {1'b0, udp_source_data[15:0]};
                    ovf_nxt  = 1'b0;
                    mask_nxt = hdr_mask;
                    pkt_inc  = udp_source_last;
                end else begin
                    mask_nxt = hdr_mask;
                    err_inc  = udp_source_last;
                end
            end
            PIXELS: if (acc) begin
                if (in_range) begin
                    en_d     = mask_q;
                    addr_d   = addr_q[15:0];
                    wdat_d   = udp_source_data[23:0];
                    addr_nxt = addr_q + 17'd1;
                end else begin
                    ovf_nxt = 1'b1;
                end
                if (udp_source_last) begin
                    if (ovf_q || !in_range) err_inc = 1'b1;
                    else                    pkt_inc = 1'b1;
                end
            end
            FILL_COLOR: if (acc) begin
                color_nxt = udp_source_data[23:0];
                if (udp_source_last) addr_nxt = '0;
                else                 err_inc  = 1'b1;
            end
            FILL: begin
                en_d     = mask_q;
                addr_d   = addr_q[15:0];
                wdat_d   = color_q;
                addr_nxt = addr_q + 17'd1;
                pkt_inc  = (addr_q == PIX_END - 17'd1);
            end
            default: ;
        endcase
    end

    // Registered outputs, datapath state and saturating counters
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            udp_source_ready <= 1'b0;
            busy             <= 1'b0;
            ctrl_en          <= '0;
            ctrl_wr          <= '0;
            ctrl_addr        <= '0;
            ctrl_wdat        <= '0;
            pkt_count        <= '0;
            err_count        <= '0;
            addr_q           <= '0;
            ovf_q            <= 1'b0;
            mask_q           <= '0;
            color_q          <= '0;
        end else begin
            udp_source_ready <= (next_state != FILL);
            busy             <= (next_state != IDLE);
            ctrl_en          <= en_d;
            ctrl_wr          <= (en_d != '0) ? 4'b0111 : 4'b0000;
            ctrl_addr        <= addr_d;
            ctrl_wdat        <= wdat_d;
            addr_q           <= addr_nxt;
            ovf_q            <= ovf_nxt;
            mask_q           <= mask_nxt;
            color_q          <= color_nxt;
            if (pkt_inc && pkt_count != 16'hFFFF) pkt_count <= pkt_count + 16'd1;
            if (err_inc && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_udp_panel_writer.sv
// tb/tb_udp_panel_writer.sv - scoreboard bench for udp_panel_writer
module tb_udp_panel_writer;

    logic        clock = 1'b0;
    logic        resetn;
    logic        valid, last, ready;
    logic [15:0] port;
    logic [31:0] data;
    logic [5:0]  ctrl_en;
    logic [3:0]  ctrl_wr;
    logic [15:0] ctrl_addr;
    logic [23:0] ctrl_wdat;
    logic        busy;
    logic [15:0] pkt_count, err_count;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_seen = 0;
    int stalls = 0;
    logic [45:0] exp_q[$];

    always #5 clock = ~clock;

    udp_panel_writer #(.NUM_PANELS(6), .PIXELS_PER_PANEL(4096), .UDP_PORT(16'd6000)) dut (
        .clock(clock), .resetn(resetn),
        .udp_source_valid(valid), .udp_source_last(last), .udp_source_ready(ready),
        .udp_source_dst_port(port), .udp_source_data(data),
        .ctrl_en(ctrl_en), .ctrl_wr(ctrl_wr), .ctrl_addr(ctrl_addr), .ctrl_wdat(ctrl_wdat),
        .busy(busy), .pkt_count(pkt_count), .err_count(err_count)
    );

    // Monitor: every write strobe must match the head of the expected queue
    always @(negedge clock) begin
        if (resetn && ctrl_en != 6'd0) begin
            logic [45:0] e;
            wr_seen++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got en=%h addr=%h wdat=%h, want no write", ctrl_en, ctrl_addr, ctrl_wdat);
            end else begin
                e = exp_q.pop_front();
                if ({ctrl_en, ctrl_addr, ctrl_wdat} != e || ctrl_wr != 4'b0111) begin
                    n_bad++;
                    $display("FAIL write: got en=%h addr=%h wdat=%h wr=%h, want en=%h addr=%h wdat=%h wr=7",
                             ctrl_en, ctrl_addr, ctrl_wdat, ctrl_wr, e[45:40], e[39:24], e[23:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [5:0] en, input logic [15:0] a, input logic [23:0] w);
        exp_q.push_back({en, a, w});
    endtask

    task automatic settle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    // Present one word, hold until accepted; entered and left at posedge+1
    task automatic send(input logic [31:0] d, input logic l, input int gap);
        int   t;
        logic r;
        valid = 1'b0;
        last  = 1'b0;
        settle(gap);
        valid = 1'b1;
        data  = d;
        last  = l;
        t = 0;
        do begin
            @(negedge clock);
            r = ready;
            if (!r) stalls++;
            @(posedge clock);
            #1;
            t++;
        end while (!r && t < 10000);
        if (!r) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got ready=0, want 1");
        end
        valid = 1'b0;
        last  = 1'b0;
    endtask

    initial begin
        int cnt;
        int base;
        resetn = 1'b0;
        valid  = 1'b0;
        last   = 1'b0;
        data   = '0;
        port   = 16'd6000;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_en", 32'(ctrl_en), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pkt", 32'(pkt_count), 0);
        chk("rst_err", 32'(err_count), 0);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        chk("ready_after_release", 32'(ready), 1);

        // Pixel stream to panel 2
        push(6'b000100, 16'h0010, 24'h112233);
        push(6'b000100, 16'h0011, 24'h445566);
        push(6'b000100, 16'h0012, 24'h778899);
        send(32'hA5020010, 1'b0, 0);
        send(32'h00112233, 1'b0, 0);
        send(32'h00445566, 1'b0, 0);
        send(32'h00778899, 1'b1, 0);
        settle(2);
        chk("t1_pkt", 32'(pkt_count), 1);
        chk("t1_busy", 32'(busy), 0);

        // Wrong destination port: dropped without backpressure
        port = 16'd6001;
        stalls = 0;
        send(32'hA5000000, 1'b0, 0);
        send(32'h00010101, 1'b0, 0);
        send(32'h00020202, 1'b0, 0);
        send(32'h00030303, 1'b1, 0);
        settle(2);
        chk("t2_stalls", 32'(stalls), 0);
        chk("t2_err", 32'(err_count), 1);
        port = 16'd6000;
        push(6'b000001, 16'h0005, 24'hABCDEF);
        send(32'hA5000005, 1'b0, 0);
        send(32'h00ABCDEF, 1'b1, 0);
        settle(2);
        chk("t2_pkt", 32'(pkt_count), 2);

        // Broadcast fill of the whole panel
        for (int i = 0; i < 4096; i++) push(6'h3F, 16'(i), 24'h0000FF);
        send(32'hF1FF0000, 1'b0, 0);
        send(32'h000000FF, 1'b1, 0);
        cnt = 0;
        while (!ready && cnt < 10000) begin
            cnt++;
            @(posedge clock);
            #1;
        end
        chk("t3_ready_low_cycles", 32'(cnt), 4096);
        settle(2);
        chk("t3_pkt", 32'(pkt_count), 3);
        chk("t3_queue_drained", 32'(exp_q.size()), 0);

        // Address overflow: no wrap, packet counted as error
        push(6'b000001, 16'h0FFE, 24'h000001);
        push(6'b000001, 16'h0FFF, 24'h000002);
        send(32'hA5000FFE, 1'b0, 0);
        send(32'hFF000001, 1'b0, 0);
        send(32'h00000002, 1'b0, 0);
        send(32'h00000003, 1'b0, 0);
        send(32'h00000004, 1'b1, 0);
        settle(2);
        chk("t4_err", 32'(err_count), 2);
        chk("t4_pkt", 32'(pkt_count), 3);

        // Bad index and unknown opcode with valid gaps
        send(32'hA5060000, 1'b0, $urandom_range(0, 2));
        send(32'h00111111, 1'b0, $urandom_range(0, 2));
        send(32'h00222222, 1'b1, $urandom_range(0, 2));
        send(32'h11000000, 1'b0, $urandom_range(0, 2));
        send(32'h00333333, 1'b1, $urandom_range(0, 2));
        settle(2);
        chk("t5_err_bad_hdr", 32'(err_count), 4);
        // Fill carrying a third word performs no fill
        send(32'hF1010000, 1'b0, 0);
        send(32'h00123456, 1'b0, 1);
        send(32'h00000000, 1'b1, 0);
        settle(2);
        chk("t5_err_fill_long", 32'(err_count), 5);
        // Header-only pixel packet is good; header-only fill is an error
        send(32'hA5030000, 1'b1, 0);
        send(32'hF1030000, 1'b1, 0);
        settle(2);
        chk("t5_pkt_empty", 32'(pkt_count), 4);
        chk("t5_err_fill_short", 32'(err_count), 6);

        // Reset during a fill after 100 writes
        for (int i = 0; i < 4096; i++) push(6'b001000, 16'(i), 24'hFF0000);
        send(32'hF1030000, 1'b0, 0);
        send(32'h00FF0000, 1'b1, 0);
        base = wr_seen;
        cnt = 0;
        while (wr_seen < base + 100 && cnt < 10000) begin
            @(negedge clock);
            #1;
            cnt++;
        end
        chk("t6_writes_before_reset", 32'(wr_seen - base), 100);
        resetn = 1'b0;
        #1;
        chk("t6_en", 32'(ctrl_en), 0);
        chk("t6_wr", 32'(ctrl_wr), 0);
        chk("t6_ready", 32'(ready), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_pkt", 32'(pkt_count), 0);
        chk("t6_err", 32'(err_count), 0);
        exp_q.delete();
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        chk("t6_ready_release", 32'(ready), 1);
        push(6'b100000, 16'h0000, 24'h345678);
        push(6'b100000, 16'h0001, 24'h9ABCDE);
        send(32'hA5050000, 1'b0, 0);
        send(32'h12345678, 1'b0, 0);
        send(32'h009ABCDE, 1'b1, 0);
        settle(3);
        chk("t6_pkt_after", 32'(pkt_count), 1);
        chk("t6_err_after", 32'(err_count), 0);
        chk("final_queue_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1);
    end

endmodule
